uart_rx_fifo_writer: RTL

Serial receive front-end placed directly upstream of the asynchronous FIFO, in the `wr_clk` domain. It recovers 8N1 frames, or frames with optional even parity, from an asynchronous `rx` pin and drives the FIFO write port with a one-cycle `wr_en` pulse per good frame. When the FIFO is full, a good frame is dropped and counted rather than written.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx_fifo_writer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front-end.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    localparam int unsigned DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

    // Saturating increment for the dropped-frame counter.
    function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous input; both stages reset to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// Serial receiver that writes each good frame into a FIFO write port.
// Frames arriving while the FIFO is full are dropped and counted.
module uart_rx_fifo_writer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    logic rxs;

    uart_rx_state_t        state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [IDX_W-1:0]      bit_idx_q,    bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q,      shift_d;
    logic                  par_bad_q,    par_bad_d;
    logic                  wr_en_q,      wr_en_d;
    logic [DATA_WIDTH-1:0] din_q,        din_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q,   drop_cnt_d;
    logic                  busy_q,       busy_d;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (wr_clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rxs)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            drop_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            drop_cnt_q   <= drop_cnt_d;
            busy_q       <= busy_d;
        end
    end

    // Frame sequencing: mid-bit sampling, parity check and the write/drop decision.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        wr_en_d      = 1'b0;
        din_d        = din_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d   = ST_START;
                    bit_idx_d = '0;
                    par_bad_d = 1'b0;
                end
            end

            ST_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            ST_PARITY: begin
                // Even parity: data bits together with the parity bit must XOR to 0.
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) ^ rxs;
                    state_d   = ST_STOP;
                end
            end

            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        // Framing error wins over parity; wait out any break.
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                        if (!fifo_full) begin
                            wr_en_d = 1'b1;
                            din_d   = shift_q;
                        end else begin
                            drop_cnt_d = drop_sat_inc(drop_cnt_q);
                        end
                    end
                end
            end

            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign wr_en      = wr_en_q;
    assign din        = din_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = busy_q;

endmodule
